// File: rtl/axis_data_unpack.sv
// H2C frame unpacker: strips the seq byte from beat 0 and rebuilds one DATA_WIDTH word; word valid 1 cycle after last beat.
// tready drops while a word waits for data_ready; optional sequence check under `SEQ_CHECK_EN.
module axis_data_unpack #(
  parameter int DATA_WIDTH      = 4064,
  parameter int AXIS_DATA_WIDTH = 512
) (
  input  logic                         s_axis_h2c_aclk,
  input  logic                         s_axis_h2c_areset,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_h2c_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_h2c_tkeep,
  input  logic                         s_axis_h2c_tlast,
  input  logic                         s_axis_h2c_tvalid,
  output logic                         s_axis_h2c_tready,
  output logic [DATA_WIDTH-1:0]        data,
  output logic                         data_valid,
  input  logic                         data_ready,
  output logic [7:0]                   frame_seq,
  output logic                         err_short,
  output logic                         err_long,
  output logic                         err_seq,
  output logic [31:0]                  frame_cnt,
  output logic [1:0]                   sstate
);

  localparam int FRAME_BEATS = 1 + (DATA_WIDTH + AXIS_DATA_WIDTH - 9) / AXIS_DATA_WIDTH;
  localparam int BCW         = $clog2(FRAME_BEATS + 1);
  localparam logic [BCW-1:0] LAST_IDX = BCW'(FRAME_BEATS - 1);
  localparam logic [DATA_WIDTH-1:0] HEAD_MASK =
    {{(DATA_WIDTH-AXIS_DATA_WIDTH+8){1'b0}}, {(AXIS_DATA_WIDTH-8){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] BEAT_MASK =
    {{(DATA_WIDTH-AXIS_DATA_WIDTH){1'b0}}, {AXIS_DATA_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_OUTPUT  = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BCW-1:0]        r_beat_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [7:0]            r_frame_seq;
  logic                  r_err_short;
  logic                  r_err_long;
  logic [31:0]           r_frame_cnt;

  logic                  w_tready;
  logic                  w_data_valid;
  logic                  w_beat;
  logic                  w_last_beat;
  logic                  w_enter_output;
  logic [31:0]           w_shift;
  logic [DATA_WIDTH-1:0] w_ins;
  logic [DATA_WIDTH-1:0] w_mask;
  logic                  w_unused_tkeep;

  // Only full beats are ever sent, so tkeep carries no information.
  assign w_unused_tkeep = ^s_axis_h2c_tkeep;

  assign w_beat         = s_axis_h2c_tvalid && w_tready;
  assign w_last_beat    = (r_beat_cnt == LAST_IDX);
  assign w_enter_output = (r_state == S_COLLECT) && w_beat && w_last_beat && s_axis_h2c_tlast;

  always_ff @(posedge s_axis_h2c_aclk) begin
    if (s_axis_h2c_areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_beat && !s_axis_h2c_tlast) w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (w_beat) begin
          if (w_last_beat)                w_state_nxt = s_axis_h2c_tlast ? S_OUTPUT : S_DRAIN;
          else if (s_axis_h2c_tlast)      w_state_nxt = S_IDLE;
        end
      end
      S_OUTPUT: begin
        if (data_ready) w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (w_beat && s_axis_h2c_tlast) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_tready     = !s_axis_h2c_areset && (r_state != S_OUTPUT);
    w_data_valid = (r_state == S_OUTPUT);
  end

  // Beat k>=1 lands just above the 504-bit head; shifts past the word simply fall off the top.
  always_comb begin
    w_shift = 32'(AXIS_DATA_WIDTH - 8) + (32'(r_beat_cnt) - 32'd1) * 32'(AXIS_DATA_WIDTH);
    if (r_state == S_IDLE) begin
      w_ins  = DATA_WIDTH'(s_axis_h2c_tdata[AXIS_DATA_WIDTH-1:8]);
      w_mask = HEAD_MASK;
    end else begin
      w_ins  = DATA_WIDTH'(s_axis_h2c_tdata) << w_shift;
      w_mask = BEAT_MASK << w_shift;
    end
  end

  always_ff @(posedge s_axis_h2c_aclk) begin
    if (s_axis_h2c_areset) begin
      r_data      <= '0;
      r_frame_seq <= '0;
      r_beat_cnt  <= '0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_beat) begin
            r_frame_seq <= s_axis_h2c_tdata[7:0];
            r_data      <= (r_data & ~w_mask) | w_ins;
            r_beat_cnt  <= BCW'(1);
            r_err_short <= s_axis_h2c_tlast;
          end
        end
        S_COLLECT: begin
          if (w_beat) begin
            r_data     <= (r_data & ~w_mask) | w_ins;
            r_beat_cnt <= r_beat_cnt + BCW'(1);
            if (w_last_beat) r_err_long  <= !s_axis_h2c_tlast;
            else             r_err_short <= s_axis_h2c_tlast;
          end
        end
        S_OUTPUT: begin
          if (data_ready) r_frame_cnt <= r_frame_cnt + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SEQ_CHECK_EN
  logic [7:0] r_exp_seq;
  logic       r_err_seq;

  // A mismatch still delivers the word; expectation resyncs to the received seq.
  always_ff @(posedge s_axis_h2c_aclk) begin
    if (s_axis_h2c_areset) begin
      r_exp_seq <= '0;
      r_err_seq <= 1'b0;
    end else begin
      r_err_seq <= w_enter_output && (r_frame_seq != r_exp_seq);
      if (w_enter_output) r_exp_seq <= r_frame_seq + 8'd1;
    end
  end

  assign err_seq = r_err_seq;
`else
  assign err_seq = 1'b0;
`endif

  assign s_axis_h2c_tready = w_tready;
  assign data_valid        = w_data_valid;
  assign data              = r_data;
  assign frame_seq         = r_frame_seq;
  assign err_short         = r_err_short;
  assign err_long          = r_err_long;
  assign frame_cnt         = r_frame_cnt;
  assign sstate            = r_state;

endmodule

// File: tb/tb_axis_data_unpack.sv
// Bench for axis_data_unpack: frames are built from a payload byte stream, expected words come from that stream.
`timescale 1ns/1ps
module tb_axis_data_unpack;

  localparam int DW     = 4064;
  localparam int AW     = 512;
  localparam int FB     = 1 + (DW + AW - 9) / AW;
  localparam int NBYTES = DW / 8;
`ifdef SEQ_CHECK_EN
  localparam int SEQ_ERRS_T5 = 1;
`else
  localparam int SEQ_ERRS_T5 = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [AW-1:0]   tdata = '0;
  logic [AW/8-1:0] tkeep = '1;
  logic            tlast = 1'b0;
  logic            tvalid = 1'b0;
  logic            tready;
  logic [DW-1:0]   data;
  logic            data_valid;
  logic            data_ready = 1'b1;
  logic [7:0]      frame_seq;
  logic            err_short, err_long, err_seq;
  logic [31:0]     frame_cnt;
  logic [1:0]      sstate;

  axis_data_unpack #(.DATA_WIDTH(DW), .AXIS_DATA_WIDTH(AW)) dut (
    .s_axis_h2c_aclk   (clk),
    .s_axis_h2c_areset (rst),
    .s_axis_h2c_tdata  (tdata),
    .s_axis_h2c_tkeep  (tkeep),
    .s_axis_h2c_tlast  (tlast),
    .s_axis_h2c_tvalid (tvalid),
    .s_axis_h2c_tready (tready),
    .data              (data),
    .data_valid        (data_valid),
    .data_ready        (data_ready),
    .frame_seq         (frame_seq),
    .err_short         (err_short),
    .err_long          (err_long),
    .err_seq           (err_seq),
    .frame_cnt         (frame_cnt),
    .sstate            (sstate)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [DW-1:0] w;
    logic [7:0]    s;
  } exp_t;
  exp_t exp_q[$];

  int         model_cnt = 0;
  int         m_short = 0, m_long = 0, m_seq = 0;
  logic [7:0] m_exp_seq = 8'd0;
  int         seen_short = 0, seen_long = 0, seen_seq = 0;
  logic [DW-1:0] last_word = '0;
  logic [7:0]    last_seq = 8'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Payload byte i of frame 'seed'; seed 0 gives incrementing bytes.
  function automatic logic [7:0] pay(input int seed, input int i);
    return 8'(i * (2 * seed + 1) + seed * 29);
  endfunction

  function automatic logic [AW-1:0] beat(input int seed, input logic [7:0] seq, input int k);
    logic [AW-1:0] b;
    b = '0;
    if (k == 0) begin
      b[7:0] = seq;
      for (int j = 1; j < AW/8; j++) b[j*8 +: 8] = pay(seed, j - 1);
    end else begin
      for (int j = 0; j < AW/8; j++) b[j*8 +: 8] = pay(seed, (AW/8 - 1) + (k - 1) * (AW/8) + j);
    end
    return b;
  endfunction

  function automatic logic [DW-1:0] ref_word(input int seed);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < NBYTES; i++) w[i*8 +: 8] = pay(seed, i);
    return w;
  endfunction

  task automatic send_frame(input int seed, input logic [7:0] seq, input int nbeats, input bit with_last);
    for (int k = 0; k < nbeats; k++) begin
      int guard;
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = beat(seed, seq, k);
      tlast  = with_last && (k == nbeats - 1);
      guard  = 0;
      while (!tready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!tready) begin
        chk("beat_accept_timeout", tready, 1);
        tvalid = 1'b0;
        tlast  = 1'b0;
        return;
      end
      @(posedge clk);
    end
    if (with_last) begin
      if (nbeats == FB) begin
`ifdef SEQ_CHECK_EN
        if (seq != m_exp_seq) m_seq++;
        m_exp_seq = seq + 8'd1;
`endif
        exp_q.push_back('{ref_word(seed), seq});
      end else if (nbeats < FB) begin
        m_short++;
      end else begin
        m_long++;
      end
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic start_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    model_cnt = 0;
    m_exp_seq = 8'd0;
  endtask

  // Compare process: every cycle out of reset, against the model queue and counters.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      chk("frame_cnt", frame_cnt, 64'(model_cnt));
      if (err_short) seen_short++;
      if (err_long)  seen_long++;
      if (err_seq)   seen_seq++;
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_data_valid", data_valid, 0);
        end else begin
          vectors++;
          if (data !== exp_q[0].w) begin
            miscompares++;
            $display("FAIL data: got low64 0x%h, expected low64 0x%h", data[63:0], exp_q[0].w[63:0]);
          end
          chk("frame_seq", frame_seq, exp_q[0].s);
          if (data_ready) begin
            last_word = data;
            last_seq  = frame_seq;
            void'(exp_q.pop_front());
            model_cnt++;
          end
        end
      end
    end
  end

  initial begin
    int bad;
    int base_seq;
    int guard;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tready", tready, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_sstate", sstate, 0);
    chk("rst_frame_seq", frame_seq, 0);
    chk("rst_errs", {err_short, err_long, err_seq}, 0);
    chk("rst_data_or", |data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("tready_after_rst", tready, 1);

    // Clean frame, incrementing bytes, seq 0
    data_ready = 1'b1;
    send_frame(0, 8'h00, FB, 1'b1);
    chk("dv_latency", data_valid, 1);
    chk("tready_in_output", tready, 0);
    repeat (2) @(negedge clk);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_dv_dropped", data_valid, 0);
    chk("t1_byte0", last_word[7:0], 8'h00);
    chk("t1_byte1", last_word[15:8], 8'h01);
    chk("t1_byte63", last_word[511:504], 8'h3F);
    chk("t1_byte507", last_word[4063:4056], 8'hFB);
    chk("t1_seq", last_seq, 8'h00);

    // Consumer stall for 20 cycles while the next frame is already offered
    data_ready = 1'b0;
    send_frame(1, 8'h01, FB, 1'b1);
    fork
      begin
        bad = 0;
        repeat (20) begin
          @(negedge clk);
          if (tready !== 1'b0 || data_valid !== 1'b1) bad++;
        end
        chk("stall_hold", bad, 0);
        data_ready = 1'b1;
      end
      send_frame(2, 8'h02, FB, 1'b1);
    join
    repeat (3) @(negedge clk);
    chk("t2_frame_cnt", frame_cnt, 3);

    // Short frames: tlast on beat 4, on beat 0, and one beat early; then a clean frame
    send_frame(3, 8'h03, 5, 1'b1);
    repeat (2) @(negedge clk);
    chk("short_b4_lit", seen_short, 1);
    send_frame(4, 8'h04, 1, 1'b1);
    send_frame(5, 8'h05, FB - 1, 1'b1);
    send_frame(6, 8'h03, FB, 1'b1);
    repeat (3) @(negedge clk);
    chk("short_total_lit", seen_short, 3);
    chk("short_vs_model", seen_short, m_short);
    chk("t3_frame_cnt", frame_cnt, 4);

    // Long frame: tlast one beat late, then a clean frame
    send_frame(7, 8'h07, FB + 1, 1'b1);
    repeat (3) @(negedge clk);
    chk("long_lit", seen_long, 1);
    chk("long_vs_model", seen_long, m_long);
    chk("t4_frame_cnt", frame_cnt, 4);
    send_frame(8, 8'h04, FB, 1'b1);
    repeat (3) @(negedge clk);
    chk("t4_after_long_cnt", frame_cnt, 5);

    // Sequence 0,1,3,4 from reset
    start_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base_seq = seen_seq;
    m_seq = 0;
    send_frame(9, 8'h00, FB, 1'b1);
    send_frame(10, 8'h01, FB, 1'b1);
    send_frame(11, 8'h03, FB, 1'b1);
    send_frame(12, 8'h04, FB, 1'b1);
    repeat (3) @(negedge clk);
    chk("t5_frame_cnt", frame_cnt, 4);
    chk("seq_err_lit", seen_seq - base_seq, SEQ_ERRS_T5);
    chk("seq_err_vs_model", seen_seq - base_seq, m_seq);
    chk("t5_last_seq", last_seq, 8'h04);

    // Reset in the middle of a frame
    send_frame(13, 8'h00, 5, 1'b0);
    start_reset();
    @(negedge clk);
    chk("midrst_tready", tready, 0);
    chk("midrst_dv", data_valid, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    chk("midrst_sstate", sstate, 0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(14, 8'h00, FB, 1'b1);
    repeat (3) @(negedge clk);
    chk("t6_frame_cnt", frame_cnt, 1);
    chk("t6_word_intact", last_word === ref_word(14), 1);

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("queue_drained", exp_q.size(), 0);
    chk("long_total", seen_long, m_long);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
